// File: rtl/digit_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : digit_match_sequencer
// Description : Scans the captured image against each digit template through
//               one shared difference unit and reports the lowest-scoring
//               digit. Optional macro DIGIT_MATCH_THRESH_EN gates match_valid
//               on the best score being <= SCORE_THRESH.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_match_sequencer #(
    parameter int NUM_DIGITS = 10,
    parameter int IMG_DIM    = 11,
    parameter int PIX_W      = 8,
    parameter int ACC_W      = 16
`ifdef DIGIT_MATCH_THRESH_EN
    ,
    parameter int SCORE_THRESH = 4000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [6:0]       pix_addr,
    output logic [3:0]       tpl_digit,
    input  logic [PIX_W-1:0] img_pixel,
    input  logic [PIX_W-1:0] tpl_pixel,
    output logic [PIX_W-1:0] diff_a,
    output logic [PIX_W-1:0] diff_b,
    input  logic [PIX_W-1:0] diff_res,
    output logic [3:0]       result_digit,
    output logic [ACC_W-1:0] result_score,
    output logic             match_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [6:0] c_LAST_PIX   = 7'(IMG_DIM * IMG_DIM - 1);
    localparam logic [3:0] c_LAST_DIGIT = 4'(NUM_DIGITS - 1);
`ifdef DIGIT_MATCH_THRESH_EN
    localparam logic [ACC_W-1:0] c_THRESH = ACC_W'(SCORE_THRESH);
`endif

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [6:0]       r_pix_addr;
    logic [3:0]       r_tpl_digit;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_best;
    logic [3:0]       r_best_digit;
    logic [3:0]       r_result_digit;
    logic [ACC_W-1:0] r_result_score;
    logic             r_match_valid;

    logic [ACC_W-1:0] w_diff_ext;
    logic             w_better;
    logic [ACC_W-1:0] w_best_score;
    logic [3:0]       w_best_digit;
    logic             w_match_ok;

    assign diff_a     = img_pixel;
    assign diff_b     = tpl_pixel;
    assign w_diff_ext = {{(ACC_W-PIX_W){1'b0}}, diff_res};

    // Strict compare: on equal scores the earlier (lower) digit is kept.
    assign w_better     = (r_acc < r_best);
    assign w_best_score = w_better ? r_acc : r_best;
    assign w_best_digit = w_better ? r_tpl_digit : r_best_digit;

`ifdef DIGIT_MATCH_THRESH_EN
    assign w_match_ok = (w_best_score <= c_THRESH);
`else
    assign w_match_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SCAN;
            S_SCAN: begin
                if (abort)                         w_state_next = S_IDLE;
                else if (r_pix_addr == c_LAST_PIX) w_state_next = S_DRAIN;
            end
            S_DRAIN: w_state_next = abort ? S_IDLE : S_CMP;
            S_CMP: begin
                if (abort)                              w_state_next = S_IDLE;
                else if (r_tpl_digit == c_LAST_DIGIT)   w_state_next = S_DONE;
                else                                    w_state_next = S_SCAN;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SCAN, S_DRAIN, S_CMP: busy = 1'b1;
            S_DONE:                 done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Read data lags the address by one cycle, so SCAN at address 0 carries
    // no valid pixel and DRAIN carries the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_addr     <= '0;
            r_tpl_digit    <= '0;
            r_acc          <= '0;
            r_best         <= '1;
            r_best_digit   <= '0;
            r_result_digit <= '0;
            r_result_score <= '0;
            r_match_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc        <= '0;
                        r_best       <= '1;
                        r_best_digit <= '0;
                        r_tpl_digit  <= '0;
                        r_pix_addr   <= '0;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        r_pix_addr  <= '0;
                        r_tpl_digit <= '0;
                    end else begin
                        if (r_pix_addr != 7'd0) r_acc <= r_acc + w_diff_ext;
                        if (r_pix_addr != c_LAST_PIX) r_pix_addr <= r_pix_addr + 7'd1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_pix_addr  <= '0;
                        r_tpl_digit <= '0;
                    end else begin
                        r_acc <= r_acc + w_diff_ext;
                    end
                end
                S_CMP: begin
                    r_acc        <= '0;
                    r_best       <= w_best_score;
                    r_best_digit <= w_best_digit;
                    if (abort) begin
                        r_pix_addr  <= '0;
                        r_tpl_digit <= '0;
                    end else if (r_tpl_digit == c_LAST_DIGIT) begin
                        r_result_digit <= w_best_digit;
                        r_result_score <= w_best_score;
                        r_match_valid  <= w_match_ok;
                    end else begin
                        r_tpl_digit <= r_tpl_digit + 4'd1;
                        r_pix_addr  <= '0;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign pix_addr     = r_pix_addr;
    assign tpl_digit    = r_tpl_digit;
    assign result_digit = r_result_digit;
    assign result_score = r_result_score;
    assign match_valid  = r_match_valid;

endmodule
`default_nettype wire

// File: tb/tb_digit_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_match_sequencer
// Description : Self-checking bench; memories with 1-cycle read latency and
//               a sum-of-|a-b| reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_match_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, match_valid;
    logic [6:0]  pix_addr;
    logic [3:0]  tpl_digit, result_digit;
    logic [7:0]  img_pixel = 8'd0, tpl_pixel = 8'd0;
    logic [7:0]  diff_a, diff_b, diff_res;
    logic [15:0] result_score;

    logic [7:0] img_mem [121];
    logic [7:0] tpl_mem [10][121];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digit_match_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .pix_addr(pix_addr), .tpl_digit(tpl_digit),
        .img_pixel(img_pixel), .tpl_pixel(tpl_pixel),
        .diff_a(diff_a), .diff_b(diff_b), .diff_res(diff_res),
        .result_digit(result_digit), .result_score(result_score),
        .match_valid(match_valid)
    );

    always @(posedge clk) begin
        if (pix_addr < 7'd121 && tpl_digit < 4'd10) begin
            img_pixel <= img_mem[pix_addr];
            tpl_pixel <= tpl_mem[tpl_digit][pix_addr];
        end else begin
            img_pixel <= 8'd0;
            tpl_pixel <= 8'd0;
        end
    end

    assign diff_res = (diff_a > diff_b) ? diff_a - diff_b : diff_b - diff_a;

    function automatic logic exp_mv(input int score);
`ifdef DIGIT_MATCH_THRESH_EN
        return score <= 4000;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model(output int bd, output int bs);
        bd = 0;
        bs = 32'h7fffffff;
        for (int d = 0; d < 10; d++) begin
            int sc = 0;
            for (int p = 0; p < 121; p++) begin
                int a = int'(img_mem[p]);
                int b = int'(tpl_mem[d][p]);
                sc += (a > b) ? a - b : b - a;
            end
            if (sc < bs) begin
                bs = sc;
                bd = d;
            end
        end
    endtask

    task automatic fill_random();
        for (int p = 0; p < 121; p++) begin
            img_mem[p] = 8'($urandom);
            for (int d = 0; d < 10; d++) tpl_mem[d][p] = 8'($urandom);
        end
    endtask

    // Pulse start, then step 1400 edges; start/abort may be raised after
    // edge k so they are sampled at edge k+1.
    task automatic do_scan(input int pulse_at, input int abort_at,
                           output int done_cycle, output int done_count,
                           output logic busy0, output logic busy_ab);
        done_cycle = -1;
        done_count = 0;
        busy_ab    = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        busy0 = busy;
        for (int k = 1; k <= 1400; k++) begin
            @(posedge clk); #1;
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = k;
            end
            if (k == abort_at + 1) busy_ab = busy;
            start = (k == pulse_at);
            abort = (k == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_result(input string name, input int cyc, input int cnt);
        int bd, bs;
        model(bd, bs);
        checks++;
        if (cyc !== 1230 || cnt !== 1) begin
            errors++;
            $display("FAIL %s done_timing: got cycle %0d count %0d, want cycle 1230 count 1", name, cyc, cnt);
        end
        checks++;
        if (result_digit !== 4'(bd)) begin
            errors++;
            $display("FAIL %s result_digit: got %0d want %0d", name, result_digit, bd);
        end
        checks++;
        if (result_score !== 16'(bs)) begin
            errors++;
            $display("FAIL %s result_score: got %0d want %0d", name, result_score, bs);
        end
        checks++;
        if (match_valid !== exp_mv(bs)) begin
            errors++;
            $display("FAIL %s match_valid: got %0b want %0b", name, match_valid, exp_mv(bs));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pix_addr, tpl_digit, result_digit, result_score, match_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b addr=%0d tpl=%0d rd=%0d rs=%0d mv=%0b want all 0",
                     busy, done, pix_addr, tpl_digit, result_digit, result_score, match_valid);
        end
        reset = 1'b0;
    endtask

    task automatic test_exact_match();
        int cyc, cnt;
        logic b0, bab;
        fill_random();
        for (int p = 0; p < 121; p++) img_mem[p] = tpl_mem[9][p];
        for (int d = 0; d < 9; d++) tpl_mem[d][0] = img_mem[0] ^ 8'h80;
        do_scan(0, 0, cyc, cnt, b0, bab);
        checks++;
        if (b0 !== 1'b1) begin
            errors++;
            $display("FAIL exact busy_after_start: got %0b want 1", b0);
        end
        check_result("exact", cyc, cnt);
        checks++;
        if (result_digit !== 4'd9 || result_score !== 16'd0) begin
            errors++;
            $display("FAIL exact_fixed: got digit %0d score %0d want 9 0", result_digit, result_score);
        end
    endtask

    task automatic test_start_ignored();
        int cyc, cnt;
        logic b0, bab;
        do_scan(300, 0, cyc, cnt, b0, bab);
        check_result("repulse", cyc, cnt);
        do_scan(0, 0, cyc, cnt, b0, bab);
        check_result("second_start", cyc, cnt);
    endtask

    task automatic test_abort();
        int cyc, cnt, bd, bs;
        logic b0, bab;
        model(bd, bs);
        do_scan(0, 500, cyc, cnt, b0, bab);
        checks++;
        if (bab !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %0b want 0", bab);
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", cnt);
        end
        checks++;
        if (result_digit !== 4'(bd) || result_score !== 16'(bs) || match_valid !== exp_mv(bs)) begin
            errors++;
            $display("FAIL abort_hold: got digit %0d score %0d mv %0b want %0d %0d %0b",
                     result_digit, result_score, match_valid, bd, bs, exp_mv(bs));
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (200) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, pix_addr, tpl_digit, result_digit, result_score, match_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%0b addr=%0d tpl=%0d rd=%0d rs=%0d mv=%0b want all 0",
                     busy, pix_addr, tpl_digit, result_digit, result_score, match_valid);
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_max_score();
        int cyc, cnt;
        logic b0, bab;
        for (int p = 0; p < 121; p++) begin
            img_mem[p] = 8'd255;
            for (int d = 0; d < 10; d++) tpl_mem[d][p] = (d == 4) ? 8'd1 : 8'd0;
        end
        do_scan(0, 0, cyc, cnt, b0, bab);
        check_result("max", cyc, cnt);
        checks++;
        if (result_digit !== 4'd4 || result_score !== 16'd30734) begin
            errors++;
            $display("FAIL max_fixed: got digit %0d score %0d want 4 30734", result_digit, result_score);
        end
    endtask

    task automatic test_tie();
        int cyc, cnt;
        logic b0, bab;
        for (int p = 0; p < 121; p++) begin
            img_mem[p] = 8'd100;
            for (int d = 0; d < 10; d++) tpl_mem[d][p] = 8'd100;
        end
        do_scan(0, 0, cyc, cnt, b0, bab);
        check_result("tie", cyc, cnt);
    endtask

    task automatic test_random();
        int cyc, cnt;
        logic b0, bab;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            do_scan(0, 0, cyc, cnt, b0, bab);
            check_result("random", cyc, cnt);
        end
    endtask

    task automatic test_thresh();
        int cyc, cnt;
        logic b0, bab;
        int targets [2] = '{3999, 4001};
        for (int t = 0; t < 2; t++) begin
            for (int p = 0; p < 121; p++) begin
                img_mem[p] = 8'd0;
                for (int d = 0; d < 10; d++) tpl_mem[d][p] = 8'd200;
                tpl_mem[6][p] = 8'(targets[t] / 121 + ((p < targets[t] % 121) ? 1 : 0));
            end
            do_scan(0, 0, cyc, cnt, b0, bab);
            check_result("thresh", cyc, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_max_score();
        test_tie();
        test_random();
        test_thresh();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_match_sequencer.md
Name: digit_match_sequencer

Overview:
- Time-multiplexed template-matching controller for the 11x11 digit recogniser.
- Replaces ten parallel per-digit difference banks with one shared per-pixel difference unit (one DiferencaEuclidiana instance, external to this block).
- Scans every pixel of the captured image against templates 0..9 in sequence, accumulates per-digit scores, and reports the digit with the lowest total.
- Sits between the image capture buffer / template ROM and the game logic that consumes the recognised digit.

Parameters:
- NUM_DIGITS, 10, number of templates scanned (digits 0..NUM_DIGITS-1).
- IMG_DIM, 11, image side length; pixels per digit = IMG_DIM*IMG_DIM = 121.
- PIX_W, 8, pixel and difference width.
- ACC_W, 16, score accumulator width; must satisfy 121*255 = 30855 < 2^ACC_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- abort  in  1  synchronous cancel of a scan in progress.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  single-cycle pulse; results valid from this cycle onward.
- pix_addr  out  7  linear pixel index row*IMG_DIM+col, range 0..120, to image buffer and template ROM.
- tpl_digit  out  4  template selector for the ROM.
- img_pixel  in  PIX_W  image buffer data; 1-cycle read latency after pix_addr.
- tpl_pixel  in  PIX_W  template ROM data; 1-cycle read latency after pix_addr/tpl_digit.
- diff_a  out  PIX_W  operand to shared difference unit (= img_pixel).
- diff_b  out  PIX_W  operand to shared difference unit (= tpl_pixel).
- diff_res  in  PIX_W  combinational result of shared difference unit.
- result_digit  out  4  best-matching digit.
- result_score  out  ACC_W  score of best digit.
- match_valid  out  1  see Optional Feature.

Behaviour:
- Reset (asynchronous, any time including mid-scan):
  - State IDLE.
  - busy, done, pix_addr, tpl_digit, result_digit, result_score = 0.
  - match_valid = 0.
  - Accumulator = 0; best score = all ones.
- FSM states: IDLE, SCAN, DRAIN, CMP, DONE.
- IDLE -> SCAN on start:
  - Clear accumulator, set best = all ones, tpl_digit = 0, pix_addr = 0.
- SCAN:
  - pix_addr increments each cycle, 0..120.
  - Data for the address issued in cycle t arrives in cycle t+1; accumulator += zero-extended diff_res in that cycle.
  - After pix_addr = 120 is issued -> DRAIN.
- DRAIN: one cycle; final accumulate for pixel 120.
- CMP: one cycle.
  - If acc < best (strict): best = acc, best_digit = tpl_digit. Ties keep the lower digit.
  - Clear accumulator.
  - If tpl_digit = NUM_DIGITS-1 -> DONE; else tpl_digit++, pix_addr = 0 -> SCAN.
- DONE: one cycle.
  - done = 1; result_digit/result_score loaded from best; busy = 0.
  - Next state IDLE.
- Timing: 123 cycles per digit. done is high in the cycle beginning 1230 clock edges after the edge that samples start.
- Results hold until the next DONE or reset.
- start while busy (SCAN/DRAIN/CMP/DONE): ignored, no queuing.
- abort in SCAN/DRAIN/CMP: next state IDLE, busy low next cycle, no done pulse, results unchanged. abort in IDLE or DONE: no effect.
- abort and start asserted together in IDLE: start wins.
- diff_a/diff_b are driven directly from img_pixel/tpl_pixel. diff_res is consumed only in the accumulate cycles (SCAN after the first address, and DRAIN).
- The image buffer must hold stable while busy; this is the producer's responsibility.
- No accumulator saturation is needed; ACC_W bounds the worst case.

Optional Feature:
- Macro: DIGIT_MATCH_THRESH_EN.
- When defined:
  - Adds parameter SCORE_THRESH (default 4000).
  - At DONE, match_valid = (best score <= SCORE_THRESH); held with the results.
- When undefined: match_valid = 1 at every DONE and held with the results.
- match_valid is 0 after reset until the first DONE in both cases.

Test Plan:
- Image identical to template 9; other templates differ; bench models diff as |a-b| -> done at edge 1230, result_digit = 9, result_score = 0.
- Image all 255; all templates 0 except template 4 all 1 -> result_digit = 4, result_score = 121*254 = 30734.
- All templates and image constant 100 -> all scores equal, result_digit = 0 (tie rule).
- start re-pulsed at cycle 300 of a scan -> ignored, done still at 1230. Second start after done -> fresh scan, same result.
- abort at cycle 500 -> busy = 0 next cycle, no done, previous results/match_valid unchanged. Reset asserted mid-SCAN -> all outputs 0 immediately (asynchronous).
- With DIGIT_MATCH_THRESH_EN: best score 3999 -> match_valid = 1; best score 4001 -> match_valid = 0.
